// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU plus an iterative shift-add multiplier and
// restoring divider, feeding the EX/MEM pipeline register.
module ex_stage_md #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 30,
  parameter int                REG_W    = 5,
  parameter int                EXP_W    = 3,
  parameter logic [EXP_W-1:0]  EXP_NONE = 0,
  parameter logic [EXP_W-1:0]  EXP_OVF  = 3,
  parameter logic [EXP_W-1:0]  EXP_DIV0 = 5
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              stall,
  input  logic              flush,
  input  logic              int_detect,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              id_en,
  input  logic [3:0]        id_alu_op,
  input  logic [1:0]        id_md_op,
  input  logic [DATA_W-1:0] id_alu_in_0,
  input  logic [DATA_W-1:0] id_alu_in_1,
  input  logic              id_br_flag,
  input  logic [1:0]        id_mem_op,
  input  logic [DATA_W-1:0] id_mem_wr_data,
  input  logic [1:0]        id_ctrl_op,
  input  logic [REG_W-1:0]  id_dst_addr,
  input  logic              id_gpr_we_,
  input  logic [EXP_W-1:0]  id_exp_code,
  output logic [ADDR_W-1:0] ex_pc,
  output logic              ex_en,
  output logic              ex_br_flag,
  output logic [1:0]        ex_mem_op,
  output logic [DATA_W-1:0] ex_mem_wr_data,
  output logic [1:0]        ex_ctrl_op,
  output logic [REG_W-1:0]  ex_dst_addr,
  output logic              ex_gpr_we_,
  output logic [EXP_W-1:0]  ex_exp_code,
  output logic [DATA_W-1:0] ex_out,
  output logic              md_busy,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_valid
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;

  md_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         md_op_q;
  logic [DATA_W-1:0]  acc;   // product accumulator / partial remainder
  logic [DATA_W-1:0]  x;     // multiplicand (shifts left) / dividend-then-quotient
  logic [DATA_W-1:0]  y;     // multiplier (shifts right) / divisor

  logic [DATA_W-1:0]  alu_res;
  logic               alu_ovf;
  logic [DATA_W:0]    div_shift;
  logic [DATA_W:0]    div_diff;
  logic               div_ge;
  logic [DATA_W-1:0]  md_res;
  logic               div0;
  logic               start;
  logic               kill;
  logic [DATA_W-1:0]  ld_out;
  logic [EXP_W-1:0]   ld_exp;

  assign kill  = flush | int_detect;
  assign start = (state == IDLE) & id_en & (id_md_op != 2'd0) & ~stall & ~kill;
  assign md_busy   = start | (state == RUN);
  assign fwd_valid = ((state == IDLE) & ~start) | (state == DONE);
  assign fwd_data  = (state == DONE) ? md_res : alu_res;

  // Single-cycle ALU with signed-overflow detection for ADD/SUB
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (id_alu_op)
      4'd0: alu_res = id_alu_in_0;
      4'd1, 4'd2: begin
        alu_res = id_alu_in_0 + id_alu_in_1;
        alu_ovf = (id_alu_op == 4'd1) &&
                  (id_alu_in_0[DATA_W-1] == id_alu_in_1[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != id_alu_in_0[DATA_W-1]);
      end
      4'd3, 4'd4: begin
        alu_res = id_alu_in_0 - id_alu_in_1;
        alu_ovf = (id_alu_op == 4'd3) &&
                  (id_alu_in_0[DATA_W-1] != id_alu_in_1[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != id_alu_in_0[DATA_W-1]);
      end
      4'd5: alu_res = id_alu_in_0 & id_alu_in_1;
      4'd6: alu_res = id_alu_in_0 | id_alu_in_1;
      4'd7: alu_res = id_alu_in_0 ^ id_alu_in_1;
      4'd8: alu_res = id_alu_in_0 >> id_alu_in_1[SH_W-1:0];
      4'd9: alu_res = id_alu_in_0 << id_alu_in_1[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // Restoring-divide trial subtraction and MD result selection
  always_comb begin
    div_shift = {acc, x[DATA_W-1]};
    div_diff  = div_shift - {1'b0, y};
    div_ge    = (div_shift >= {1'b0, y});
    md_res    = (md_op_q == 2'd2) ? x : acc;
    div0      = (md_op_q[1] == 1'b1) && (y == '0);
  end

  // Values the EX/MEM register takes on a normal load
  always_comb begin
    ld_out = (state == DONE) ? md_res : alu_res;
    ld_exp = EXP_NONE;
    if (id_en) begin
      if (id_exp_code != EXP_NONE)
        ld_exp = id_exp_code;
      else if ((state == DONE) && div0)
        ld_exp = EXP_DIV0;
      else if ((state != DONE) && (id_md_op == 2'd0) && alu_ovf)
        ld_exp = EXP_OVF;
    end
  end

  // MD sequencer: one quotient/product bit per unstalled RUN cycle
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      cnt     <= '0;
      md_op_q <= '0;
      acc     <= '0;
      x       <= '0;
      y       <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else if (!stall) begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          cnt     <= '0;
          md_op_q <= id_md_op;
          acc     <= '0;
          x       <= id_alu_in_0;
          y       <= id_alu_in_1;
        end
        RUN: begin
          if (md_op_q == 2'd1) begin
            if (y[0]) acc <= acc + x;
            x <= x << 1;
            y <= y >> 1;
          end else begin
            acc <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
            x   <= {x[DATA_W-2:0], div_ge};
          end
          if (cnt == CNT_W'(DATA_W - 1)) state <= DONE;
          else cnt <= cnt + CNT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // EX/MEM register: kill > stall-hold > busy-bubble > load
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ex_pc          <= '0;
      ex_en          <= 1'b0;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= '0;
      ex_mem_wr_data <= '0;
      ex_ctrl_op     <= '0;
      ex_dst_addr    <= '0;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= EXP_NONE;
      ex_out         <= '0;
    end else if (kill || (!stall && md_busy)) begin
      ex_pc          <= id_pc;
      ex_en          <= 1'b0;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= '0;
      ex_mem_wr_data <= id_mem_wr_data;
      ex_ctrl_op     <= '0;
      ex_dst_addr    <= id_dst_addr;
      ex_gpr_we_     <= 1'b1;
      ex_exp_code    <= EXP_NONE;
      ex_out         <= '0;
    end else if (!stall) begin
      ex_pc          <= id_pc;
      ex_en          <= id_en;
      ex_br_flag     <= id_br_flag;
      ex_mem_op      <= id_mem_op;
      ex_mem_wr_data <= id_mem_wr_data;
      ex_ctrl_op     <= id_ctrl_op;
      ex_dst_addr    <= id_dst_addr;
      ex_gpr_we_     <= id_gpr_we_ | (ld_exp != EXP_NONE);
      ex_exp_code    <= ld_exp;
      ex_out         <= ld_out;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: ALU ops against an arithmetic model,
// MD ops against native * / % with latency, stall, flush and reset scenarios.
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        reset_;
  logic        stall, flush, int_detect;
  logic [29:0] id_pc;
  logic        id_en;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_md_op;
  logic [31:0] id_alu_in_0, id_alu_in_1;
  logic        id_br_flag;
  logic [1:0]  id_mem_op;
  logic [31:0] id_mem_wr_data;
  logic [1:0]  id_ctrl_op;
  logic [4:0]  id_dst_addr;
  logic        id_gpr_we_;
  logic [2:0]  id_exp_code;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag, ex_gpr_we_;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic        md_busy, fwd_valid;
  logic [31:0] fwd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage_md #(.DATA_W(32), .ADDR_W(30), .REG_W(5), .EXP_W(3)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .int_detect(int_detect),
    .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op), .id_md_op(id_md_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1), .id_br_flag(id_br_flag),
    .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op),
    .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .md_busy(md_busy), .fwd_data(fwd_data), .fwd_valid(fwd_valid)
  );

  // Reference ALU: signed overflow judged on the mathematically exact result
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ovf);
    longint s;
    ovf = 0;
    case (op)
      4'd0: r = a;
      4'd1, 4'd2: begin
        r = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        ovf = (op == 4'd1) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'd3, 4'd4: begin
        r = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        ovf = (op == 4'd3) && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = a >> (b % 32);
      4'd9: r = a << (b % 32);
      default: r = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    case (op)
      2'd1: begin p = longint'(a) * longint'(b); return p[31:0]; end
      2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic set_id(input logic [3:0] aop, input logic [1:0] mop,
                        input logic [31:0] a, input logic [31:0] b);
    id_en = 1'b1; id_alu_op = aop; id_md_op = mop;
    id_alu_in_0 = a; id_alu_in_1 = b;
    id_pc = 30'($urandom); id_br_flag = 1'($urandom); id_mem_op = 2'($urandom);
    id_mem_wr_data = $urandom; id_ctrl_op = 2'($urandom); id_dst_addr = 5'($urandom);
    id_gpr_we_ = 1'b0; id_exp_code = 3'd0;
  endtask

  task automatic idle_id();
    id_en = 1'b0; id_md_op = 2'd0; id_alu_op = 4'd0;
  endtask

  // Drive an MD op and follow it to the edge where ex_en rises
  task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len,
                        output int lat, output int busy_cnt, output bit bubbles_ok,
                        output bit run_fwd_ok, output logic [31:0] done_fwd, output logic done_fv);
    set_id(4'd1, op, a, b);
    lat = 0; busy_cnt = 0; bubbles_ok = 1; run_fwd_ok = 1; done_fwd = 'x; done_fv = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      stall = (stall_len > 0) && (k >= stall_at) && (k < stall_at + stall_len);
      #1;
      if (md_busy) begin
        busy_cnt++;
        if (fwd_valid) run_fwd_ok = 0;
      end else begin
        done_fwd = fwd_data; done_fv = fwd_valid;
      end
      @(posedge clk); #1;
      if (ex_en) begin lat = k; break; end
      if (ex_out !== 32'd0 || ex_gpr_we_ !== 1'b1 || ex_exp_code !== 3'd0) bubbles_ok = 0;
    end
    stall = 1'b0;
  endtask

  task automatic test_reset();
    reset_ = 1'b0; stall = 0; flush = 0; int_detect = 0;
    set_id(4'd1, 2'd0, 32'd1, 32'd2); idle_id();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ex_pc !== 0 || ex_en !== 0 || ex_br_flag !== 0 || ex_mem_op !== 0 || ex_mem_wr_data !== 0 ||
        ex_ctrl_op !== 0 || ex_dst_addr !== 0 || ex_out !== 0) begin
      bad++; $display("FAIL reset_zero: en=%0b out=%h pc=%h", ex_en, ex_out, ex_pc);
    end
    total++;
    if (ex_gpr_we_ !== 1'b1 || ex_exp_code !== 3'd0 || md_busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags: gpr_we_=%0b exp=%0d busy=%0b (want 1 0 0)", ex_gpr_we_, ex_exp_code, md_busy);
    end
    @(negedge clk); reset_ = 1'b1;
  endtask

  task automatic test_alu_random();
    logic [31:0] a, b, r; logic [3:0] op; bit ovf; logic [2:0] e_exp; logic e_gpr;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 11));
      case ($urandom_range(0, 3))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      set_id(op, 2'd0, a, b);
      id_gpr_we_ = 1'($urandom);
      if ($urandom_range(0, 7) == 0) id_exp_code = 3'($urandom_range(1, 7));
      ref_alu(op, a, b, r, ovf);
      e_exp = (id_exp_code != 0) ? id_exp_code : (ovf ? 3'd3 : 3'd0);
      e_gpr = id_gpr_we_ | (e_exp != 0);
      #1;
      total++;
      if (fwd_valid !== 1'b1 || fwd_data !== r) begin
        bad++; $display("FAIL alu_fwd op=%0d: valid=%0b data=%h want 1 %h", op, fwd_valid, fwd_data, r);
      end
      @(posedge clk); #1;
      total++;
      if (ex_out !== r || ex_en !== 1'b1) begin
        bad++; $display("FAIL alu_out op=%0d a=%h b=%h: got %h want %h", op, a, b, ex_out, r);
      end
      total++;
      if (ex_exp_code !== e_exp || ex_gpr_we_ !== e_gpr) begin
        bad++; $display("FAIL alu_exp op=%0d: exp=%0d gpr_we_=%0b want %0d %0b", op, ex_exp_code, ex_gpr_we_, e_exp, e_gpr);
      end
      total++;
      if (ex_pc !== id_pc || ex_dst_addr !== id_dst_addr || ex_mem_op !== id_mem_op ||
          ex_mem_wr_data !== id_mem_wr_data || ex_ctrl_op !== id_ctrl_op || ex_br_flag !== id_br_flag) begin
        bad++; $display("FAIL alu_pass: pc=%h dst=%0d want %h %0d", ex_pc, ex_dst_addr, id_pc, id_dst_addr);
      end
    end
    @(negedge clk); idle_id();
  endtask

  task automatic test_overflow();
    @(negedge clk);
    set_id(4'd1, 2'd0, 32'h7FFF_FFFF, 32'h1); id_dst_addr = 5'd3;
    @(posedge clk); #1;
    total++;
    if (ex_out !== 32'h8000_0000 || ex_exp_code !== 3'd3 || ex_gpr_we_ !== 1'b1 || ex_en !== 1'b1) begin
      bad++; $display("FAIL add_ovf: out=%h exp=%0d gpr_we_=%0b en=%0b", ex_out, ex_exp_code, ex_gpr_we_, ex_en);
    end
    @(negedge clk); id_alu_op = 4'd2;
    @(posedge clk); #1;
    total++;
    if (ex_out !== 32'h8000_0000 || ex_exp_code !== 3'd0 || ex_gpr_we_ !== 1'b0) begin
      bad++; $display("FAIL addu_noovf: out=%h exp=%0d gpr_we_=%0b", ex_out, ex_exp_code, ex_gpr_we_);
    end
    @(negedge clk); idle_id();
  endtask

  task automatic test_md_directed();
    int lat, bc; bit bok, rok; logic [31:0] df; logic dv;
    logic [1:0]  ops [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [31:0] as  [4] = '{32'd7, 32'd100, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'd6, 32'd7, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] ws  [4] = '{32'd42, 32'd14, 32'd2, 32'd1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      run_md(ops[i], as[i], bs[i], 0, 0, lat, bc, bok, rok, df, dv);
      total++;
      if (lat !== 34 || bc !== 33) begin
        bad++; $display("FAIL md_timing[%0d]: latency=%0d busy=%0d want 34 33", i, lat, bc);
      end
      total++;
      if (ex_out !== ws[i] || ex_exp_code !== 3'd0 || ex_gpr_we_ !== 1'b0) begin
        bad++; $display("FAIL md_result[%0d]: out=%h exp=%0d want %h 0", i, ex_out, ex_exp_code, ws[i]);
      end
      total++;
      if (!bok || !rok || dv !== 1'b1 || df !== ws[i]) begin
        bad++; $display("FAIL md_side[%0d]: bubbles=%0b runfwd=%0b donefv=%0b donefwd=%h", i, bok, rok, dv, df);
      end
      idle_id();
    end
  endtask

  task automatic test_div0();
    int lat, bc; bit bok, rok; logic [31:0] df; logic dv;
    @(negedge clk);
    run_md(2'd2, 32'd5, 32'd0, 0, 0, lat, bc, bok, rok, df, dv);
    total++;
    if (lat !== 34 || ex_out !== 32'hFFFF_FFFF || ex_exp_code !== 3'd5 || ex_gpr_we_ !== 1'b1) begin
      bad++; $display("FAIL divu_zero: lat=%0d out=%h exp=%0d gpr_we_=%0b", lat, ex_out, ex_exp_code, ex_gpr_we_);
    end
    idle_id();
    @(negedge clk);
    run_md(2'd3, 32'd5, 32'd0, 0, 0, lat, bc, bok, rok, df, dv);
    total++;
    if (lat !== 34 || ex_out !== 32'd5 || ex_exp_code !== 3'd5 || ex_gpr_we_ !== 1'b1) begin
      bad++; $display("FAIL remu_zero: lat=%0d out=%h exp=%0d gpr_we_=%0b", lat, ex_out, ex_exp_code, ex_gpr_we_);
    end
    idle_id();
  endtask

  task automatic test_md_random();
    int lat, bc; bit bok, rok; logic [31:0] df, a, b, w; logic dv; logic [1:0] op;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      op = 2'($urandom_range(1, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      w = ref_md(op, a, b);
      run_md(op, a, b, 0, 0, lat, bc, bok, rok, df, dv);
      total++;
      if (lat !== 34 || ex_out !== w ||
          ex_exp_code !== ((op != 2'd1 && b == 0) ? 3'd5 : 3'd0)) begin
        bad++; $display("FAIL md_rand op=%0d a=%h b=%h: lat=%0d out=%h want %h exp=%0d", op, a, b, lat, ex_out, w, ex_exp_code);
      end
      idle_id();
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit bok, rok; logic [31:0] df; logic dv;
    @(negedge clk);
    run_md(2'd1, 32'd3, 32'd5, 0, 0, lat, bc, bok, rok, df, dv);
    total++;
    if (lat !== 34 || ex_out !== 32'd15) begin
      bad++; $display("FAIL b2b_first: lat=%0d out=%h want 34 0000000f", lat, ex_out);
    end
    run_md(2'd2, 32'd99, 32'd9, 0, 0, lat, bc, bok, rok, df, dv);
    total++;
    if (lat !== 34 || bc !== 33 || ex_out !== 32'd11) begin
      bad++; $display("FAIL b2b_second: lat=%0d busy=%0d out=%h want 34 33 0000000b", lat, bc, ex_out);
    end
    idle_id();
  endtask

  task automatic test_stall();
    int lat, bc; bit bok, rok; logic [31:0] df; logic dv;
    @(negedge clk);
    set_id(4'd1, 2'd0, 32'd1, 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    stall = 1'b1; id_alu_in_0 = 32'd10; id_alu_in_1 = 32'd20;
    @(posedge clk); #1;
    total++;
    if (ex_out !== 32'd3) begin
      bad++; $display("FAIL stall_hold: out=%h want 00000003", ex_out);
    end
    @(negedge clk); stall = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ex_out !== 32'd30) begin
      bad++; $display("FAIL stall_release: out=%h want 0000001e", ex_out);
    end
    @(negedge clk);
    run_md(2'd2, 32'd100, 32'd7, 10, 4, lat, bc, bok, rok, df, dv);
    total++;
    if (lat !== 38 || bc !== 37 || ex_out !== 32'd14 || !bok) begin
      bad++; $display("FAIL md_stall: lat=%0d busy=%0d out=%h bubbles=%0b want 38 37 0000000e 1", lat, bc, ex_out, bok);
    end
    idle_id();
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_id(4'd1, 2'd1, 32'd7, 32'd6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; id_pc = 30'h155;
    @(posedge clk); #1;
    total++;
    if (ex_en !== 1'b0 || ex_pc !== 30'h155 || ex_out !== 32'd0) begin
      bad++; $display("FAIL flush_bubble: en=%0b pc=%h out=%h", ex_en, ex_pc, ex_out);
    end
    flush = 1'b0; idle_id(); #1;
    total++;
    if (md_busy !== 1'b0 || fwd_valid !== 1'b1) begin
      bad++; $display("FAIL flush_idle: busy=%0b fwd_valid=%0b want 0 1", md_busy, fwd_valid);
    end
    @(negedge clk);
    set_id(4'd1, 2'd0, 32'd2, 32'd3);
    @(posedge clk); #1;
    total++;
    if (ex_out !== 32'd5 || ex_en !== 1'b1) begin
      bad++; $display("FAIL flush_next_add: out=%h en=%0b want 00000005 1", ex_out, ex_en);
    end
    @(negedge clk);
    set_id(4'd1, 2'd2, 32'd50, 32'd5);
    repeat (3) @(posedge clk);
    @(negedge clk); int_detect = 1'b1;
    @(posedge clk); #1;
    int_detect = 1'b0; idle_id(); #1;
    total++;
    if (ex_en !== 1'b0 || md_busy !== 1'b0) begin
      bad++; $display("FAIL int_abort: en=%0b busy=%0b want 0 0", ex_en, md_busy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_id(4'd1, 2'd1, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #2;
    reset_ = 1'b0; idle_id();
    #1;
    total++;
    if (ex_en !== 0 || ex_out !== 0 || ex_pc !== 0 || ex_gpr_we_ !== 1 || ex_exp_code !== 0 ||
        md_busy !== 0 || fwd_valid !== 1) begin
      bad++; $display("FAIL reset_mid: en=%0b out=%h gpr_we_=%0b busy=%0b fv=%0b", ex_en, ex_out, ex_gpr_we_, md_busy, fwd_valid);
    end
    @(negedge clk); reset_ = 1'b1;
    @(negedge clk);
    set_id(4'd3, 2'd0, 32'd10, 32'd4);
    @(posedge clk); #1;
    total++;
    if (ex_out !== 32'd6 || ex_en !== 1'b1) begin
      bad++; $display("FAIL after_reset_sub: out=%h en=%0b want 00000006 1", ex_out, ex_en);
    end
    @(negedge clk); idle_id();
  endtask

  initial begin
    test_reset();
    test_alu_random();
    test_overflow();
    test_md_directed();
    test_div0();
    test_md_random();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage with an iterative multiply/divide unit. It sits between the ID/EX and EX/MEM boundaries, in the same pipeline position as the current execute stage. Single-cycle ALU ops pass straight into the EX/MEM register. MUL/DIVU/REMU run on a shift-add / restoring-divide datapath over DATA_W cycles, and the block raises `md_busy` so the pipeline controller holds upstream stages. It also provides forwarding data with a validity qualifier and raises overflow and divide-by-zero exceptions.

## Interface
- DATA_W, 32, datapath width (≥8)
- ADDR_W, 30, word-address width of pc
- REG_W, 5, register-address width
- EXP_W, 3, exception-code width
- EXP_NONE / EXP_OVF / EXP_DIV0, 0 / 3 / 5, exception codes emitted
- clk  in  1  clock, all state on rising edge
- reset_  in  1  asynchronous, active-low reset
- stall  in  1  hold EX/MEM register and MD state
- flush  in  1  load bubble, abort MD op
- int_detect  in  1  same effect as flush
- id_pc  in  ADDR_W  instruction pc
- id_en  in  1  instruction valid
- id_alu_op  in  4  0 PASS(in_0), 1 ADD, 2 ADDU, 3 SUB, 4 SUBU, 5 AND, 6 OR, 7 XOR, 8 SHRL, 9 SHLL
- id_md_op  in  2  0 none, 1 MUL (low DATA_W), 2 DIVU, 3 REMU; non-zero overrides id_alu_op
- id_alu_in_0, id_alu_in_1  in  DATA_W  operands
- id_br_flag  in  1  passthrough
- id_mem_op  in  2  passthrough
- id_mem_wr_data  in  DATA_W  passthrough
- id_ctrl_op  in  2  passthrough
- id_dst_addr  in  REG_W  passthrough
- id_gpr_we_  in  1  active-low write enable, passthrough
- id_exp_code  in  EXP_W  incoming exception
- ex_pc, ex_en, ex_br_flag, ex_mem_op, ex_mem_wr_data, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out  out  matching widths  EX/MEM register
- md_busy  out  1  MD op in progress; controller stalls IF/ID and holds id_* stable
- fwd_data  out  DATA_W  current-cycle result for forwarding
- fwd_valid  out  1  fwd_data is final (0 while md_busy)

## Operation
- Reset: all ex_* are 0, except ex_gpr_we_=1 and ex_exp_code=EXP_NONE. FSM is IDLE, counter is 0, md_busy=0.
- ALU: shifts use in_1[log2(DATA_W)-1:0]. ADD/SUB set overflow on a signed carry mismatch; ADDU/SUBU never do.
- Overflow: ex_exp_code=EXP_OVF, ex_gpr_we_=1, ex_en=id_en. A non-zero id_exp_code takes priority and passes through unchanged.
- Exceptions are evaluated only when id_en=1.
- MD FSM states: IDLE, RUN, DONE.
  - start = IDLE & id_en & id_md_op≠0 & !stall & !flush & !int_detect.
  - IDLE→RUN on start. Latch operands and op; counter=0; clear partial product/remainder.
  - RUN: one bit per cycle. MUL: shift-add on the multiplier LSB. DIV: restoring — shift remainder left, subtract divisor, keep if non-negative, quotient bit = not-borrow. Counter increments; RUN→DONE when counter=DATA_W-1.
  - DONE: result valid. DONE→IDLE on the next unstalled edge, and the EX/MEM register captures the result that edge.
- md_busy = (IDLE & start) | RUN. It is combinational, so the controller stalls in the issue cycle.
- Divisor 0: DIVU result is all-ones, REMU result is the dividend, ex_exp_code=EXP_DIV0, ex_gpr_we_=1.
  - The full iteration is still run, so latency stays fixed.
- EX/MEM register update priority:
  1. reset
  2. flush | int_detect → bubble
  3. stall → hold
  4. md_busy → bubble
  5. otherwise load
- Bubble: ex_en=0, ex_gpr_we_=1, ex_mem_op=0, ex_ctrl_op=0, ex_exp_code=EXP_NONE, ex_out=0, and ex_pc=id_pc.
- fwd_data: equals the ALU result in IDLE and the MD result in DONE.
- fwd_valid: 1 in IDLE with no start, and 1 in DONE; 0 in all other cycles.

## Timing
- ALU op: one cycle latency; the EX/MEM register loads on the edge after presentation.
- MD op: the issue edge enters RUN, then DATA_W RUN cycles, then one DONE cycle.
  - The result appears on ex_* DATA_W+2 edges after issue; md_busy is high for DATA_W+1 cycles.
- stall during RUN/DONE: counter and datapath frozen, state held.
- flush/int_detect in RUN or DONE: FSM→IDLE on that edge, result discarded, bubble loaded.
- flush and start in the same cycle: no start.
- Back-to-back MD ops: the next one may start in the cycle after DONE.
- id_* must stay stable while md_busy=1 (controller responsibility); the block samples operands only at start.
- reset_ asserted mid-operation: immediate return to reset state.

## Test plan
- ADD 0x7FFFFFFF+0x00000001, dst 3, gpr_we_=0 → next edge: ex_out=0x80000000, ex_exp_code=EXP_OVF, ex_gpr_we_=1; ADDU with the same operands → no exception, ex_gpr_we_=0.
- MUL 7×6 → md_busy high 33 cycles; ex_out=42 and ex_en=1 exactly 34 edges after issue; bubbles on ex_* while busy; fwd_valid=0 during RUN.
- DIVU 100/7 → ex_out=14; REMU 100/7 → ex_out=2; MUL 0xFFFFFFFF×0xFFFFFFFF → ex_out=0x00000001.
- DIVU 5/0 → ex_out=0xFFFFFFFF, ex_exp_code=EXP_DIV0, ex_gpr_we_=1; REMU 5/0 → ex_out=5.
- MUL issued, flush asserted at RUN cycle 10 → ex_en=0 next edge, md_busy=0, FSM IDLE; a following ADD 2+3 gives ex_out=5 one edge later.
- DIVU 100/7 with stall held 4 cycles mid-RUN → ex_out=14 arrives 4 edges late; ex_* held during the stall; reset_ low mid-RUN → all outputs at reset values immediately.
